// File: rtl/mem_stage_if.sv
// Bus bundle for mem_stage: execute-side access, LSU request/response and writeback.
// slave is the stage's view; master is the surrounding pipeline/LSU view.
interface mem_stage_if;
  logic        valid_i;
  logic        ready_o;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;

  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  wsel_byte_o;
  logic [31:0] wdata_o;
  logic        req_stall_i;
  logic        req_done_i;
  logic [31:0] rdata_i;

  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic [31:0] fault_addr_o;

  modport slave (
    input  valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i, rd_i,
    input  req_stall_i, req_done_i, rdata_i,
    output ready_o, req_o, we_o, addr_o, wsel_byte_o, wdata_o,
    output wb_valid_o, wb_rd_o, wb_data_o, misalign_o, fault_addr_o
  );

  modport master (
    output valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i, rd_i,
    output req_stall_i, req_done_i, rdata_i,
    input  ready_o, req_o, we_o, addr_o, wsel_byte_o, wdata_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, misalign_o, fault_addr_o
  );
endinterface

// File: rtl/mem_stage.sv
// Yarc memory-access stage: one outstanding load/store between execute and the LSU.
// Define MEM_STAGE_MISALIGN_SPLIT_EN to split word-crossing accesses into two requests instead of trapping.
module mem_stage (
  input logic        clk_i,
  input logic        rst_i,
  mem_stage_if.slave bus
);

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, REQ2, WAIT2, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, TRAP} state_t;
`endif

  state_t      state_q, state_d;

  logic        accept;
  logic        final_done;
  logic [1:0]  off_in;
  logic        crosses;
  logic [3:0]  base_sel;
  logic [3:0]  wsel_in;
  logic [31:0] wdata_rep;
  logic [31:0] load_shifted;

  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  wsel_q;
  logic [31:0] wdata_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
  logic [7:0]  wsel_wide;
  logic [63:0] wdata_pair;
  logic [5:0]  rot_idx;
  logic [31:0] wdata_rot;
  logic [63:0] load_pair;
  logic        split_q;
  logic [3:0]  wsel_hi_q;
  logic [31:0] rdata_lo_q;
`else
  logic [31:0] fault_q;
`endif

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic uns);
    if (sz[1])
      return d;
    else if (sz == 2'b01)
      return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
    else
      return uns ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
  endfunction

  // Decode the incoming access: crossing detection, byte enables and replicated store data.
  always_comb begin
    accept  = bus.valid_i && (state_q == IDLE);
    off_in  = bus.addr_i[1:0];
    crosses = ((bus.size_i == 2'b01) && (off_in == 2'd3)) || (bus.size_i[1] && (off_in != 2'd0));
    case (bus.size_i)
      2'b00: begin
        base_sel  = 4'b0001;
        wdata_rep = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        base_sel  = 4'b0011;
        wdata_rep = {2{bus.wdata_i[15:0]}};
      end
      default: begin
        base_sel  = 4'b1111;
        wdata_rep = bus.wdata_i;
      end
    endcase
    wsel_in = base_sel << off_in;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
    wsel_wide    = {4'b0000, base_sel} << off_in;
    wdata_pair   = {bus.wdata_i, bus.wdata_i};
    rot_idx      = 6'd32 - {1'b0, off_in, 3'b000};
    wdata_rot    = wdata_pair[rot_idx +: 32];
    load_pair    = (state_q == WAIT2) ? {bus.rdata_i, rdata_lo_q} : {32'h0, bus.rdata_i};
    load_shifted = load_pair[{off_q, 3'b000} +: 32];
    final_done   = bus.req_done_i && (((state_q == WAIT) && !split_q) || (state_q == WAIT2));
`else
    load_shifted = bus.rdata_i >> {off_q, 3'b000};
    final_done   = bus.req_done_i && (state_q == WAIT);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
          state_d = REQ;
`else
          state_d = crosses ? TRAP : REQ;
`endif
        end
      end
      REQ:  if (!bus.req_stall_i) state_d = WAIT;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
      WAIT: if (bus.req_done_i) state_d = split_q ? REQ2 : IDLE;
      REQ2: if (!bus.req_stall_i) state_d = WAIT2;
      WAIT2: if (bus.req_done_i) state_d = IDLE;
`else
      WAIT: if (bus.req_done_i) state_d = IDLE;
`endif
      TRAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the access on acceptance; the LSU request fields stay frozen until the next part or access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wsel_q     <= 4'h0;
      wdata_q    <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      wsel_hi_q  <= 4'h0;
      rdata_lo_q <= 32'h0;
`else
      fault_q    <= 32'h0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      if (accept) begin
        size_q  <= bus.size_i;
        uns_q   <= bus.unsigned_i;
        off_q   <= off_in;
        rd_q    <= bus.rd_i;
        we_q    <= bus.we_i;
        addr_q  <= {bus.addr_i[31:2], 2'b00};
        wsel_q  <= wsel_in;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
        wdata_q   <= crosses ? wdata_rot : wdata_rep;
        split_q   <= crosses;
        wsel_hi_q <= wsel_wide[7:4];
`else
        wdata_q <= wdata_rep;
        if (crosses) fault_q <= bus.addr_i;
`endif
      end
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
      if ((state_q == WAIT) && bus.req_done_i && split_q) begin
        rdata_lo_q <= bus.rdata_i;
        addr_q     <= addr_q + 32'd4;
        wsel_q     <= wsel_hi_q;
      end
`endif
      if (final_done && !we_q) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_data_q  <= extend(load_shifted, size_q, uns_q);
      end
    end
  end

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
  assign bus.req_o        = (state_q == REQ) || (state_q == REQ2);
  assign bus.misalign_o   = 1'b0;
  assign bus.fault_addr_o = 32'h0;
`else
  assign bus.req_o        = (state_q == REQ);
  assign bus.misalign_o   = (state_q == TRAP);
  assign bus.fault_addr_o = fault_q;
`endif
  assign bus.ready_o     = (state_q == IDLE);
  assign bus.we_o        = we_q;
  assign bus.addr_o      = addr_q;
  assign bus.wsel_byte_o = wsel_q;
  assign bus.wdata_o     = wdata_q;
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_rd_o     = wb_rd_q;
  assign bus.wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: hand-written vectors, randomized accesses against a
// byte-level reference model, and reset-during-access sequences.
module tb_mem_stage;

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;

  mem_stage_if bus ();

  mem_stage dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          stall;
    int          lat;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    int          exp_nreq;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wsel;
    logic [3:0]  exp_wsel2;
    logic [31:0] exp_wdata;
    int          exp_nwb;
    logic [31:0] exp_wbdata;
    int          exp_ntrap;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int          obs_nreq;
  logic [31:0] obs_addr [2];
  logic [3:0]  obs_wsel [2];
  logic [31:0] obs_wdata [2];
  logic        obs_we [2];
  int          obs_nwb;
  logic [31:0] obs_wbdata;
  logic [4:0]  obs_wbrd;
  int          obs_ntrap;
  logic [31:0] obs_fault;
  logic        obs_first_req;
  logic        obs_first_trap;
  logic        obs_stable;
  logic        obs_timeout;

  function automatic vec_t mkIn(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                                input int stall, input int lat, input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.stall = stall; v.lat = lat; v.rdata0 = r0; v.rdata1 = r1;
    v.exp_nreq = 0; v.exp_addr = 0; v.exp_wsel = 0; v.exp_wsel2 = 0; v.exp_wdata = 0;
    v.exp_nwb = 0; v.exp_wbdata = 0; v.exp_ntrap = 0;
    return v;
  endfunction

  function automatic vec_t withExp(input vec_t v, input int nreq, input logic [31:0] addr,
                                   input logic [3:0] wsel, input logic [3:0] wsel2, input logic [31:0] wdata,
                                   input int nwb, input logic [31:0] wbdata, input int ntrap);
    vec_t r;
    r = v;
    r.exp_nreq = nreq; r.exp_addr = addr; r.exp_wsel = wsel; r.exp_wsel2 = wsel2;
    r.exp_wdata = wdata; r.exp_nwb = nwb; r.exp_wbdata = wbdata; r.exp_ntrap = ntrap;
    return r;
  endfunction

  // Reference model: treats the access as n consecutive bytes starting at addr and maps each onto a word lane.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int n;
    int off;
    int pos;
    logic [31:0] ld;
    logic [31:0] src;
    r = withExp(v, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0, 32'h0, 0);
    n = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    off = int'(v.addr[1:0]);
    ld = 32'h0;
    r.exp_addr = v.addr & 32'hFFFF_FFFC;
    if ((off + n > 4) && !SPLIT) begin
      r.exp_ntrap = 1;
      return r;
    end
    r.exp_nreq = (off + n > 4) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      pos = off + k;
      src = (pos < 4) ? v.rdata0 : v.rdata1;
      if (pos < 4) r.exp_wsel[pos] = 1'b1;
      else         r.exp_wsel2[pos - 4] = 1'b1;
      ld[8*k +: 8] = src[8*(pos % 4) +: 8];
    end
    for (int j = 0; j < 4; j++) begin
      if (r.exp_nreq == 2) r.exp_wdata[8*j +: 8] = v.wdata[8*((j - off + 4) % 4) +: 8];
      else                 r.exp_wdata[8*j +: 8] = v.wdata[8*(j % n) +: 8];
    end
    if (!v.we) begin
      r.exp_nwb = 1;
      if (n == 1)      r.exp_wbdata = v.uns ? {24'h0, ld[7:0]} : {{24{ld[7]}}, ld[7:0]};
      else if (n == 2) r.exp_wbdata = v.uns ? {16'h0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};
      else             r.exp_wbdata = ld;
    end
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one access from a negedge with ready_o high, plays the LSU, and records what the stage did.
  task automatic applyStimulus(input vec_t v);
    int  cyc;
    int  stall_left;
    int  cnt;
    bit  pending;
    bit  seen;
    bit  done_flag;
    logic [31:0] hold_addr;
    logic [3:0]  hold_wsel;
    logic [31:0] hold_wdata;
    obs_nreq = 0; obs_nwb = 0; obs_ntrap = 0;
    obs_wbdata = 32'h0; obs_wbrd = 5'd0; obs_fault = 32'h0;
    obs_first_req = 1'b0; obs_first_trap = 1'b0; obs_stable = 1'b1; obs_timeout = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs_addr[i] = 32'h0; obs_wsel[i] = 4'h0; obs_wdata[i] = 32'h0; obs_we[i] = 1'b0;
    end
    hold_addr = 32'h0; hold_wsel = 4'h0; hold_wdata = 32'h0;
    cyc = 0;
    while (!bus.ready_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!bus.ready_o) begin
      obs_timeout = 1'b1;
      return;
    end
    bus.valid_i = 1'b1; bus.we_i = v.we; bus.size_i = v.size; bus.unsigned_i = v.uns;
    bus.addr_i = v.addr; bus.wdata_i = v.wdata; bus.rd_i = v.rd;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    obs_first_req  = bus.req_o;
    obs_first_trap = bus.misalign_o;
    stall_left = v.stall; pending = 1'b0; seen = 1'b0; cnt = 0; done_flag = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      bus.req_done_i = 1'b0;
      bus.req_stall_i = 1'b0;
      if (bus.wb_valid_o) begin
        obs_nwb++;
        obs_wbdata = bus.wb_data_o;
        obs_wbrd = bus.wb_rd_o;
      end
      if (bus.misalign_o) begin
        obs_ntrap++;
        obs_fault = bus.fault_addr_o;
      end
      if (bus.ready_o) begin
        done_flag = 1'b1;
        break;
      end
      if (pending) begin
        if (cnt == 0) begin
          bus.req_done_i = 1'b1;
          bus.rdata_i = (obs_nreq <= 1) ? v.rdata0 : v.rdata1;
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end else if (bus.req_o) begin
        if (!seen) begin
          hold_addr = bus.addr_o; hold_wsel = bus.wsel_byte_o; hold_wdata = bus.wdata_o;
          seen = 1'b1;
        end else if (bus.addr_o !== hold_addr || bus.wsel_byte_o !== hold_wsel || bus.wdata_o !== hold_wdata) begin
          obs_stable = 1'b0;
        end
        if (stall_left > 0) begin
          bus.req_stall_i = 1'b1;
          stall_left--;
        end else begin
          if (obs_nreq < 2) begin
            obs_addr[obs_nreq] = bus.addr_o;
            obs_wsel[obs_nreq] = bus.wsel_byte_o;
            obs_wdata[obs_nreq] = bus.wdata_o;
            obs_we[obs_nreq] = bus.we_o;
          end
          obs_nreq++;
          pending = 1'b1;
          cnt = v.lat;
          seen = 1'b0;
        end
      end
      @(negedge clk_i);
    end
    if (!done_flag) obs_timeout = 1'b1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, ".timeout"}, 32'(obs_timeout), 32'h0);
    checkVal({tag, ".nreq"}, obs_nreq, v.exp_nreq);
    checkVal({tag, ".reqAfterAccept"}, 32'(obs_first_req), 32'(v.exp_nreq > 0));
    checkVal({tag, ".trapAfterAccept"}, 32'(obs_first_trap), 32'(v.exp_ntrap > 0));
    if (v.exp_nreq > 0) begin
      checkVal({tag, ".addr"}, obs_addr[0], v.exp_addr);
      checkVal({tag, ".wsel"}, 32'(obs_wsel[0]), 32'(v.exp_wsel));
      checkVal({tag, ".we"}, 32'(obs_we[0]), 32'(v.we));
      checkVal({tag, ".stable"}, 32'(obs_stable), 32'h1);
      if (v.we) checkVal({tag, ".wdata"}, obs_wdata[0], v.exp_wdata);
    end
    if (v.exp_nreq > 1) begin
      checkVal({tag, ".addr2"}, obs_addr[1], v.exp_addr + 32'd4);
      checkVal({tag, ".wsel2"}, 32'(obs_wsel[1]), 32'(v.exp_wsel2));
      if (v.we) checkVal({tag, ".wdata2"}, obs_wdata[1], v.exp_wdata);
    end
    checkVal({tag, ".nwb"}, obs_nwb, v.exp_nwb);
    if (v.exp_nwb > 0) begin
      checkVal({tag, ".wbdata"}, obs_wbdata, v.exp_wbdata);
      checkVal({tag, ".wbrd"}, 32'(obs_wbrd), 32'(v.rd));
    end
    checkVal({tag, ".ntrap"}, obs_ntrap, v.exp_ntrap);
    if (v.exp_ntrap > 0) checkVal({tag, ".faultAddr"}, obs_fault, v.addr);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [11];
    vec_t v;
    int   nwb_seen;

    rst_i = 1'b1;
    bus.valid_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
    bus.addr_i = 32'h0; bus.wdata_i = 32'h0; bus.rd_i = 5'd0;
    bus.req_stall_i = 1'b0; bus.req_done_i = 1'b0; bus.rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);

    checkVal("reset.ready", 32'(bus.ready_o), 32'h1);
    checkVal("reset.req", 32'(bus.req_o), 32'h0);
    checkVal("reset.we", 32'(bus.we_o), 32'h0);
    checkVal("reset.addr", bus.addr_o, 32'h0);
    checkVal("reset.wsel", 32'(bus.wsel_byte_o), 32'h0);
    checkVal("reset.wdata", bus.wdata_o, 32'h0);
    checkVal("reset.wbValid", 32'(bus.wb_valid_o), 32'h0);
    checkVal("reset.wbRd", 32'(bus.wb_rd_o), 32'h0);
    checkVal("reset.wbData", bus.wb_data_o, 32'h0);
    checkVal("reset.misalign", 32'(bus.misalign_o), 32'h0);
    checkVal("reset.faultAddr", bus.fault_addr_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    tbl[0] = withExp(mkIn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd5, 0, 1, 32'h80AA_BBCC, 32'h0),
                     1, 32'h0000_1000, 4'b1000, 4'b0000, 32'h0, 1, 32'hFFFF_FF80, 0);
    tbl[1] = withExp(mkIn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 0, 0, 32'h0, 32'h0),
                     1, 32'h0000_2000, 4'b1100, 4'b0000, 32'hABCD_ABCD, 0, 32'h0, 0);
    tbl[2] = withExp(mkIn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd7, 3, 0, 32'hDEAD_BEEF, 32'h0),
                     1, 32'h0000_4000, 4'b1111, 4'b0000, 32'h0, 1, 32'hDEAD_BEEF, 0);
    if (SPLIT)
      tbl[3] = withExp(mkIn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd9, 0, 0, 32'h4433_2211, 32'h8877_6655),
                       2, 32'h0000_3000, 4'b1110, 4'b0001, 32'h0, 1, 32'h5544_3322, 0);
    else
      tbl[3] = withExp(mkIn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd9, 0, 0, 32'h4433_2211, 32'h8877_6655),
                       0, 32'h0000_3000, 4'b0000, 4'b0000, 32'h0, 0, 32'h0, 1);
    tbl[4] = withExp(mkIn(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 5'd1, 0, 0, 32'h9ABC_8765, 32'h0),
                     1, 32'h0000_0010, 4'b0011, 4'b0000, 32'h0, 1, 32'h0000_8765, 0);
    tbl[5] = withExp(mkIn(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 5'd2, 0, 0, 32'h9ABC_8765, 32'h0),
                     1, 32'h0000_0010, 4'b0010, 4'b0000, 32'h0, 1, 32'hFFFF_FF87, 0);
    tbl[6] = withExp(mkIn(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00A5, 5'd0, 0, 2, 32'h0, 32'h0),
                     1, 32'h0000_5000, 4'b0010, 4'b0000, 32'hA5A5_A5A5, 0, 32'h0, 0);
    tbl[7] = withExp(mkIn(1'b0, 2'b00, 1'b1, 32'h0000_6002, 32'h0, 5'd3, 0, 1, 32'h00F0_0000, 32'h0),
                     1, 32'h0000_6000, 4'b0100, 4'b0000, 32'h0, 1, 32'h0000_00F0, 0);
    tbl[8] = withExp(mkIn(1'b0, 2'b01, 1'b0, 32'h0000_7002, 32'h0, 5'd4, 1, 0, 32'h8001_0000, 32'h0),
                     1, 32'h0000_7000, 4'b1100, 4'b0000, 32'h0, 1, 32'hFFFF_8001, 0);
    tbl[9] = withExp(mkIn(1'b0, 2'b11, 1'b1, 32'h0000_8000, 32'h0, 5'd6, 0, 0, 32'hCAFE_F00D, 32'h0),
                     1, 32'h0000_8000, 4'b1111, 4'b0000, 32'h0, 1, 32'hCAFE_F00D, 0);
    if (SPLIT)
      tbl[10] = withExp(mkIn(1'b1, 2'b01, 1'b0, 32'h0000_9003, 32'h0000_BEEF, 5'd0, 0, 0, 32'h0, 32'h0),
                        2, 32'h0000_9000, 4'b1000, 4'b0001, 32'hEF00_00BE, 0, 32'h0, 0);
    else
      tbl[10] = withExp(mkIn(1'b1, 2'b01, 1'b0, 32'h0000_9003, 32'h0000_BEEF, 5'd0, 0, 0, 32'h0, 32'h0),
                        0, 32'h0000_9000, 4'b0000, 4'b0000, 32'h0, 0, 32'h0, 1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      v = mkIn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
               $urandom_range(0, 3), $urandom, $urandom);
      v = model(v);
      applyStimulus(v);
      checkOutput(v, $sformatf("rand%0d", i));
    end

    // Reset while a stalled request is on the bus must drop req_o without waiting for a clock edge.
    bus.valid_i = 1'b1; bus.we_i = 1'b0; bus.size_i = 2'b10; bus.addr_i = 32'h0000_0100; bus.rd_i = 5'd8;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    bus.req_stall_i = 1'b1;
    checkVal("rstReq.reqBefore", 32'(bus.req_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    checkVal("rstReq.reqAsyncDrop", 32'(bus.req_o), 32'h0);
    checkVal("rstReq.readyAsync", 32'(bus.ready_o), 32'h1);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.req_stall_i = 1'b0;

    // Reset while waiting for completion; the late completion must be ignored.
    bus.valid_i = 1'b1; bus.addr_i = 32'h0000_0200; bus.rd_i = 5'd9;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    checkVal("rstWait.reqIssued", 32'(bus.req_o), 32'h1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.req_done_i = 1'b1;
    bus.rdata_i = 32'h1234_5678;
    nwb_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      bus.req_done_i = 1'b0;
      if (bus.wb_valid_o) nwb_seen++;
    end
    checkVal("rstWait.noWb", nwb_seen, 0);
    checkVal("rstWait.req", 32'(bus.req_o), 32'h0);
    checkVal("rstWait.ready", 32'(bus.ready_o), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
